id_branch_stage: RTL
====================

ID_BRANCH_STAGE -- requirements
Module: id_branch_stage

Interface
REQ-001 Parameter DECODE_WIDTH, 2, number of decode lanes per bundle (1..4).
REQ-002 Lane-indexed buses SHALL pack lane i at [i*W +: W]; N = DECODE_WIDTH.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  pipeline flush.
REQ-006 in_valid  input  1  upstream bundle valid.
REQ-007 in_ready  output  1  block can accept a bundle.
REQ-008 in_lane_valid  input  N  per-lane valid.
REQ-009 in_pc  input  N*32  lane PCs.
REQ-010 in_inst  input  N*32  lane instruction words.
REQ-011 out_valid  output  1  downstream bundle valid.
REQ-012 out_ready  input  1  downstream accepts bundle.
REQ-013 out_lane_valid  output  N  lane carries a live instruction.
REQ-014 out_is_branch  output  N  lane decoded as a 2RI16/2RI26 branch or jump.
REQ-015 out_pc  output  N*32  lane PC passed through.
REQ-016 out_aluop / out_alusel  output  N*8 / N*3  ALU op and select.
REQ-017 out_imm  output  N*32  sign-extended byte offset.
REQ-018 out_target  output  N*32  precomputed pc+imm.
REQ-019 out_reg1_en, out_reg2_en, out_wen  output  N each  read/write enables.
REQ-020 out_reg1_addr, out_reg2_addr, out_waddr  output  N*5 each  register addresses.
REQ-021 out_pred_taken  output  N  static prediction.

Function
REQ-022 Opcode inst[31:26]: JIRL 010011, B 010100, BL 010101, BEQ 010110, BNE 010111, BLT 011000, BGE 011001, BLTU 011010, BGEU 011011; others: is_branch=0, aluop=ALU_NOP, alusel=ALU_SEL_NOP, all enables 0.
REQ-023 Conditional branches: reg1=rj inst[9:5], reg2=rd inst[4:0], both read, wen=0, each opcode its own aluop (BEQ->ALU_BEQ, never ALU_ORI).
REQ-024 B: no reads, wen=0; BL: no reads, wen=1, waddr=1; JIRL: reg1=rj read, wen=1, waddr=rd; rd=0 SHALL force wen=0.
REQ-025 imm = sext({inst[25:10],2'b00}) for offs16 ops; sext({inst[9:0],inst[25:10],2'b00}) for B/BL; target = pc+imm modulo 2^32 (JIRL target unused, still computed).
REQ-026 Decode result SHALL appear on outputs exactly 1 cycle after acceptance (in_valid && in_ready) when out_ready is held 1.
REQ-027 Storage: main output register plus one-bundle skid register; in_ready = skid empty, driven from a flop.
REQ-028 Accept while main full and !out_ready -> bundle goes to skid; out_ready with skid full -> skid moves to main same edge, skid empties.
REQ-029 Throughput: one bundle per cycle sustained while out_ready=1; no bundle lost or duplicated under any out_ready pattern.
REQ-030 Bundle with no in_lane_valid bit set SHALL be accepted and dropped (out_valid not raised).
REQ-031 Lane kill: B or BL in lane i clears out_lane_valid for lanes j>i in the same bundle; JIRL does not kill.
REQ-032 flush SHALL empty main and skid next edge, dominate a simultaneous acceptance (bundle discarded) and in_ready=1 the cycle after.
REQ-033 Outputs hold stable while out_valid && !out_ready.

Reset
REQ-034 rst_n low: out_valid=0, skid empty, in_ready=1 after release, all data outputs 0.
REQ-035 Reset mid-operation SHALL discard main and skid contents immediately.

Configuration
REQ-036 Macro STATIC_PREDICT_EN defined: out_pred_taken=1 for B, BL and conditional branches with negative imm; predicted-taken conditional lane also kills younger lanes per REQ-031.
REQ-037 Macro undefined: out_pred_taken=1 only for B/BL; conditional branches never kill lanes.

Structure
REQ-038 Opcode constants, ALU_* and ALU_SEL_* codes SHALL live in the shared defines file, not locally.
REQ-039 Per-lane combinational decode SHALL be sub-module branch_lane_decode, instantiated N times; lane kill, skid and handshake stay in id_branch_stage.

Verification
REQ-040 N=2, lane0 BEQ inst 0x5800_0C41 pc 0x1C00_0000 -> 1 cycle later aluop ALU_BEQ, reg1=2, reg2=1, imm=0xC, target 0x1C00_000C.
REQ-041 Lane0 BL offs26=-1 pc 0x1C00_0100 -> wen=1, waddr=1, target 0x1C00_00FC, lane1 out_lane_valid=0.
REQ-042 out_ready low 3 cycles over 3 offered bundles -> in_ready drops after 2nd accepted, bundles emerge in order, none lost.
REQ-043 flush with in_valid=1 and skid full -> next cycle out_valid=0, in_ready=1, bundle never appears.
REQ-044 Lane0 BNE imm=-8 -> pred_taken=1 and lane1 killed with STATIC_PREDICT_EN; pred_taken=0, lane1 live without.
REQ-045 rst_n asserted while out_valid && !out_ready -> out_valid=0 immediately; JIRL rd=0 -> wen=0.

Source files
------------

// File: rtl/id_branch_stage_pkg.sv
// id_branch_stage_pkg -- shared defines for the branch decode stage.
//   Opcode constants (inst[31:26]), ALU_* operation codes, ALU_SEL_* select
//   codes, and the per-lane decode record carried through the stage registers.
package id_branch_stage_pkg;

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_JIRL = 8'h40;
  localparam logic [7:0] ALU_B    = 8'h41;
  localparam logic [7:0] ALU_BL   = 8'h42;
  localparam logic [7:0] ALU_BEQ  = 8'h43;
  localparam logic [7:0] ALU_BNE  = 8'h44;
  localparam logic [7:0] ALU_BLT  = 8'h45;
  localparam logic [7:0] ALU_BGE  = 8'h46;
  localparam logic [7:0] ALU_BLTU = 8'h47;
  localparam logic [7:0] ALU_BGEU = 8'h48;

  localparam logic [2:0] ALU_SEL_NOP  = 3'b000;
  localparam logic [2:0] ALU_SEL_JUMP = 3'b101;

  // Decoded lane as held in the main/skid registers.
  typedef struct packed {
    logic [31:0] pc;
    logic        is_branch;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] imm;
    logic [31:0] target;
    logic        reg1_en;
    logic        reg2_en;
    logic        wen;
    logic [4:0]  reg1_addr;
    logic [4:0]  reg2_addr;
    logic [4:0]  waddr;
    logic        pred_taken;
  } lane_dec_t;

  // ALU op for the six conditional branches; ALU_NOP for anything else.
  function automatic logic [7:0] cond_aluop(input logic [5:0] op);
    case (op)
      OP_BEQ:  return ALU_BEQ;
      OP_BNE:  return ALU_BNE;
      OP_BLT:  return ALU_BLT;
      OP_BGE:  return ALU_BGE;
      OP_BLTU: return ALU_BLTU;
      OP_BGEU: return ALU_BGEU;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_branch_stage_if.sv
// id_branch_stage_if -- upstream/downstream bundle bus of the branch decode stage.
//   Lane i of every lane-indexed bus sits at [i*W +: W].
//   master : the environment (drives in_* bundle and out_ready)
//   slave  : id_branch_stage (drives in_ready and all out_* signals)
interface id_branch_stage_if #(
  parameter int N = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_lane_valid;
  logic [N*32-1:0] in_pc;
  logic [N*32-1:0] in_inst;

  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_lane_valid;
  logic [N-1:0]    out_is_branch;
  logic [N*32-1:0] out_pc;
  logic [N*8-1:0]  out_aluop;
  logic [N*3-1:0]  out_alusel;
  logic [N*32-1:0] out_imm;
  logic [N*32-1:0] out_target;
  logic [N-1:0]    out_reg1_en;
  logic [N-1:0]    out_reg2_en;
  logic [N-1:0]    out_wen;
  logic [N*5-1:0]  out_reg1_addr;
  logic [N*5-1:0]  out_reg2_addr;
  logic [N*5-1:0]  out_waddr;
  logic [N-1:0]    out_pred_taken;

  modport master (
    output in_valid, in_lane_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_is_branch, out_pc,
           out_aluop, out_alusel, out_imm, out_target, out_reg1_en,
           out_reg2_en, out_wen, out_reg1_addr, out_reg2_addr, out_waddr,
           out_pred_taken
  );

  modport slave (
    input  in_valid, in_lane_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_lane_valid, out_is_branch, out_pc,
           out_aluop, out_alusel, out_imm, out_target, out_reg1_en,
           out_reg2_en, out_wen, out_reg1_addr, out_reg2_addr, out_waddr,
           out_pred_taken
  );
endinterface

// File: rtl/id_branch_stage_lane_decode.sv
// branch_lane_decode -- combinational decode of one lane (branches/jumps only).
//   pc, inst   : lane PC and instruction word
//   valid      : lane carries a live instruction
//   dec        : decoded record (imm, target = pc + imm, enables, addresses)
//   kill       : this lane redirects fetch, so younger lanes must be dropped
// Build option: STATIC_PREDICT_EN -- backward (negative offset) conditional
//   branches are predicted taken and kill younger lanes.
module branch_lane_decode
  import id_branch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        valid,
  output lane_dec_t   dec,
  output logic        kill
);

  logic [5:0]  op;
  logic [4:0]  rj, rd;
  logic [31:0] offs16, offs26;

  assign op     = inst[31:26];
  assign rj     = inst[9:5];
  assign rd     = inst[4:0];
  assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // value unassigned -- that is what keeps this block from inferring latches.
    dec    = '0;
    dec.pc = pc;
    case (op)
      OP_JIRL: begin
        dec.is_branch = 1'b1;
        dec.aluop     = ALU_JIRL;
        dec.alusel    = ALU_SEL_JUMP;
        dec.imm       = offs16;
        dec.reg1_en   = 1'b1;
        dec.reg1_addr = rj;
        dec.wen       = (rd != 5'd0);   // link into r0 is no write
        dec.waddr     = rd;
      end
      OP_B, OP_BL: begin
        dec.is_branch  = 1'b1;
        dec.aluop      = (op == OP_BL) ? ALU_BL : ALU_B;
        dec.alusel     = ALU_SEL_JUMP;
        dec.imm        = offs26;
        dec.wen        = (op == OP_BL);
        dec.waddr      = (op == OP_BL) ? 5'd1 : 5'd0;
        dec.pred_taken = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        dec.is_branch = 1'b1;
        dec.aluop     = cond_aluop(op);
        dec.alusel    = ALU_SEL_JUMP;
        dec.imm       = offs16;
        dec.reg1_en   = 1'b1;
        dec.reg1_addr = rj;
        dec.reg2_en   = 1'b1;
        dec.reg2_addr = rd;
      end
      default: ;
    endcase
`ifdef STATIC_PREDICT_EN
    if (cond_aluop(op) != ALU_NOP && offs16[31]) dec.pred_taken = 1'b1;
`endif
    dec.target = pc + dec.imm;
    // Any predicted-taken lane redirects fetch; JIRL is never predicted here.
    kill = valid && dec.pred_taken;
  end

endmodule

// File: rtl/id_branch_stage.sv
// id_branch_stage -- branch/jump decode stage with one-bundle skid buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties main and skid registers on the next edge
//   bus        : id_branch_stage_if.slave (in_* bundle in, out_* decoded bundle)
// A bundle accepted on edge k appears on out_* after edge k. When the main
// register is stalled, one further bundle is parked in the skid register and
// in_ready drops until it drains. Bundles with no live lane are swallowed.
// Build option: STATIC_PREDICT_EN (see branch_lane_decode).
module id_branch_stage
  import id_branch_stage_pkg::*;
#(
  parameter int DECODE_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  id_branch_stage_if.slave     bus
);

  localparam int N = DECODE_WIDTH;

  lane_dec_t [N-1:0] lane_dec;
  logic      [N-1:0] lane_kill;
  logic      [N-1:0] new_lv;
  logic              killed;

  lane_dec_t [N-1:0] main_lanes, skid_lanes;
  logic      [N-1:0] main_lv, skid_lv;
  logic              main_valid, skid_valid, in_ready_q;
  logic              push;

  for (genvar i = 0; i < N; i++) begin : g_dec
    branch_lane_decode u_dec (
      .pc    (bus.in_pc[i*32 +: 32]),
      .inst  (bus.in_inst[i*32 +: 32]),
      .valid (bus.in_lane_valid[i]),
      .dec   (lane_dec[i]),
      .kill  (lane_kill[i])
    );
  end

  // Lane kill: a redirecting lane drops every younger lane of the bundle.
  always_comb begin
    new_lv = '0;
    killed = 1'b0;
    for (int i = 0; i < N; i++) begin
      // NOTE: blocking '=' here is deliberate: 'killed' must carry lane i's
      // result into lane i+1 within the same evaluation.
      new_lv[i] = bus.in_lane_valid[i] & ~killed;
      killed    = killed | lane_kill[i];
    end
  end

  assign push = bus.in_valid && in_ready_q && (|bus.in_lane_valid);

  // NOTE: non-blocking '<=' for all state so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, not just the valids, because
      // the decoded outputs must read as zero out of reset.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_lanes <= '0;
      main_lv    <= '0;
      skid_lanes <= '0;
      skid_lv    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (!main_valid || bus.out_ready) begin
      // Main register is free this edge: refill from skid first (older),
      // otherwise from the incoming bundle.
      if (skid_valid) begin
        main_lanes <= skid_lanes;
        main_lv    <= skid_lv;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (push) begin
        main_lanes <= lane_dec;
        main_lv    <= new_lv;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (push) begin
      skid_lanes <= lane_dec;
      skid_lv    <= new_lv;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;

  for (genvar i = 0; i < N; i++) begin : g_out
    assign bus.out_lane_valid[i]        = main_lv[i];
    assign bus.out_is_branch[i]         = main_lanes[i].is_branch;
    assign bus.out_pc[i*32 +: 32]       = main_lanes[i].pc;
    assign bus.out_aluop[i*8 +: 8]      = main_lanes[i].aluop;
    assign bus.out_alusel[i*3 +: 3]     = main_lanes[i].alusel;
    assign bus.out_imm[i*32 +: 32]      = main_lanes[i].imm;
    assign bus.out_target[i*32 +: 32]   = main_lanes[i].target;
    assign bus.out_reg1_en[i]           = main_lanes[i].reg1_en;
    assign bus.out_reg2_en[i]           = main_lanes[i].reg2_en;
    assign bus.out_wen[i]               = main_lanes[i].wen;
    assign bus.out_reg1_addr[i*5 +: 5]  = main_lanes[i].reg1_addr;
    assign bus.out_reg2_addr[i*5 +: 5]  = main_lanes[i].reg2_addr;
    assign bus.out_waddr[i*5 +: 5]      = main_lanes[i].waddr;
    assign bus.out_pred_taken[i]        = main_lanes[i].pred_taken;
  end

endmodule
